// File: rtl/cla_pkg.sv
// Shared types and the second-level carry lookahead for the pipelined CLA adder/subtractor.
package cla_pkg;

    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_ADDC, OP_SUBB} op_t;

    localparam int unsigned GROUP_W    = 4;
    localparam int unsigned MAX_GROUPS = 64;

    // Each group carry is its own sum of products over G/P/c0, so there is no ripple between groups.
    function automatic logic [MAX_GROUPS:0] group_carries(
        input logic [MAX_GROUPS-1:0] g_grp,
        input logic [MAX_GROUPS-1:0] p_grp,
        input logic                  c0,
        input int unsigned           ngroup
    );
        logic [MAX_GROUPS:0] c;
        logic                carry;
        logic                prod;
        c    = '0;
        c[0] = c0;
        for (int unsigned i = 0; i < ngroup; i++) begin
            carry = 1'b0;
            for (int unsigned j = 0; j <= i; j++) begin
                prod = g_grp[j];
                for (int unsigned k = j + 1; k <= i; k++) begin
                    prod = prod & p_grp[k];
                end
                carry = carry | prod;
            end
            prod = c0;
            for (int unsigned k = 0; k <= i; k++) begin
                prod = prod & p_grp[k];
            end
            c[i+1] = carry | prod;
        end
        return c;
    endfunction

endpackage

// File: rtl/cla_group4.sv
// Combinational 4-bit carry-lookahead group: group G/P, in-group carries and sum bits.
module cla_group4 (
    input  logic [3:0] g_i,
    input  logic [3:0] p_i,
    input  logic       c_i,
    output logic       g_grp_o,
    output logic       p_grp_o,
    output logic [3:0] sum_o,
    output logic [3:0] carry_o
);

    always_comb begin
        carry_o[0] = c_i;
        carry_o[1] = g_i[0] | (p_i[0] & c_i);
        carry_o[2] = g_i[1] | (p_i[1] & g_i[0]) | (p_i[1] & p_i[0] & c_i);
        carry_o[3] = g_i[2] | (p_i[2] & g_i[1]) | (p_i[2] & p_i[1] & g_i[0])
                   | (p_i[2] & p_i[1] & p_i[0] & c_i);
        g_grp_o    = g_i[3] | (p_i[3] & g_i[2]) | (p_i[3] & p_i[2] & g_i[1])
                   | (p_i[3] & p_i[2] & p_i[1] & g_i[0]);
        p_grp_o    = &p_i;
        // a ^ b' recovered as p & ~g, so only g/p need to travel with the beat
        sum_o      = (p_i & ~g_i) ^ carry_o;
    end

endmodule

// File: rtl/cla_pipe_addsub.sv
// Two-stage pipelined CLA adder/subtractor: stage 1 forms bit/group g/p, stage 2 resolves carries and flags.
module cla_pipe_addsub
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_t              op,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned NGROUP = WIDTH / GROUP_W;

    if ((WIDTH % GROUP_W) != 0 || WIDTH < GROUP_W || NGROUP >= MAX_GROUPS) begin : g_bad_width
        $error("cla_pipe_addsub: WIDTH must be a multiple of 4, at least 4 and below 256");
    end

    logic              ready1, ready2;
    logic [WIDTH-1:0]  b_cond, g_bit, p_bit;
    logic              c0_cond;
    logic [NGROUP-1:0] gg_s1, pg_s1;
    logic [WIDTH-1:0]  s1_sum_unused, s1_carry_unused;

    logic              v1_q, v1_d, c0_q, c0_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, g_q, g_d, p_q, p_d;
    logic [NGROUP-1:0] gg_q, gg_d, pg_q, pg_d;

    logic              v2_q, v2_d, cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;
    logic [WIDTH-1:0]  s_q, s_d, sum2;

    always_comb begin
        b_cond  = b;
        c0_cond = 1'b0;
        unique case (op)
            OP_ADD:  begin b_cond = b;  c0_cond = 1'b0; end
            OP_SUB:  begin b_cond = ~b; c0_cond = 1'b1; end
            OP_ADDC: begin b_cond = b;  c0_cond = cin;  end
            OP_SUBB: begin b_cond = ~b; c0_cond = ~cin; end
        endcase
    end

    assign g_bit = a & b_cond;
    assign p_bit = a | b_cond;

    for (genvar k = 0; k < NGROUP; k++) begin : g_s1
        cla_group4 u_grp (
            .g_i     (g_bit[GROUP_W*k +: GROUP_W]),
            .p_i     (p_bit[GROUP_W*k +: GROUP_W]),
            .c_i     (1'b0),
            .g_grp_o (gg_s1[k]),
            .p_grp_o (pg_s1[k]),
            .sum_o   (s1_sum_unused[GROUP_W*k +: GROUP_W]),
            .carry_o (s1_carry_unused[GROUP_W*k +: GROUP_W])
        );
    end

    assign ready2   = !v2_q || out_ready;
    assign ready1   = !v1_q || ready2;
    assign in_ready = ready1;

    always_comb begin
        v1_d = v1_q; a_d = a_q; b_d = b_q; c0_d = c0_q;
        g_d  = g_q;  p_d = p_q; gg_d = gg_q; pg_d = pg_q;
        if (ready1) begin
            v1_d = in_valid;
            if (in_valid) begin
                a_d = a; b_d = b_cond; c0_d = c0_cond;
                g_d = g_bit; p_d = p_bit; gg_d = gg_s1; pg_d = pg_s1;
            end
        end
    end

    logic [MAX_GROUPS-1:0]        gg_ext, pg_ext;
    logic [MAX_GROUPS:0]          cgrp_all;
    logic [NGROUP:0]              cgrp;
    logic [MAX_GROUPS-NGROUP-1:0] cgrp_unused;
    logic [NGROUP-1:0]            s2_g_unused, s2_p_unused;
    logic [WIDTH-1:0]             s2_carry_unused;
    logic [2*WIDTH-3:0]           ab_low_unused;

    always_comb begin
        gg_ext             = '0;
        pg_ext             = '0;
        gg_ext[NGROUP-1:0] = gg_q;
        pg_ext[NGROUP-1:0] = pg_q;
        cgrp_all           = group_carries(gg_ext, pg_ext, c0_q, NGROUP);
    end

    assign cgrp          = cgrp_all[NGROUP:0];
    assign cgrp_unused   = cgrp_all[MAX_GROUPS:NGROUP+1];
    assign ab_low_unused = {a_q[WIDTH-2:0], b_q[WIDTH-2:0]};

    for (genvar k = 0; k < NGROUP; k++) begin : g_s2
        cla_group4 u_grp (
            .g_i     (g_q[GROUP_W*k +: GROUP_W]),
            .p_i     (p_q[GROUP_W*k +: GROUP_W]),
            .c_i     (cgrp[k]),
            .g_grp_o (s2_g_unused[k]),
            .p_grp_o (s2_p_unused[k]),
            .sum_o   (sum2[GROUP_W*k +: GROUP_W]),
            .carry_o (s2_carry_unused[GROUP_W*k +: GROUP_W])
        );
    end

    always_comb begin
        v2_d = v2_q; s_d = s_q; cout_d = cout_q; ovf_d = ovf_q; zero_d = zero_q;
        if (ready2) begin
            v2_d = v1_q;
            if (v1_q) begin
                s_d    = sum2;
                cout_d = cgrp[NGROUP];
                ovf_d  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum2[WIDTH-1] != a_q[WIDTH-1]);
                zero_d = (sum2 == '0);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q <= 1'b0; a_q <= '0; b_q <= '0; c0_q <= 1'b0;
            g_q  <= '0;   p_q <= '0; gg_q <= '0; pg_q <= '0;
            v2_q <= 1'b0; s_q <= '0; cout_q <= 1'b0; ovf_q <= 1'b0; zero_q <= 1'b0;
        end else begin
            v1_q <= v1_d; a_q <= a_d; b_q <= b_d; c0_q <= c0_d;
            g_q  <= g_d;  p_q <= p_d; gg_q <= gg_d; pg_q <= pg_d;
            v2_q <= v2_d; s_q <= s_d; cout_q <= cout_d; ovf_q <= ovf_d; zero_q <= zero_d;
        end
    end

    assign out_valid = v2_q;
    assign s         = s_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Directed bench for cla_pipe_addsub at WIDTH 16, 32 and 4 with hand-computed results.
module tb_cla_pipe_addsub;
    import cla_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, in_valid, in_ready, cin, out_valid, out_ready, cout, ovf, zero;
    logic [15:0] a, b, s;
    op_t         op;

    logic        w32_in_valid, w32_in_ready, w32_out_valid, w32_cout, w32_ovf, w32_zero;
    logic [31:0] w32_a, w32_b, w32_s;
    logic        w4_in_valid, w4_in_ready, w4_out_valid, w4_cout, w4_ovf, w4_zero;
    logic [3:0]  w4_a, w4_b, w4_s;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    cla_pipe_addsub #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .cout(cout), .ovf(ovf), .zero(zero)
    );

    cla_pipe_addsub #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(w32_in_valid), .in_ready(w32_in_ready),
        .a(w32_a), .b(w32_b), .op(OP_ADD), .cin(1'b0), .out_valid(w32_out_valid),
        .out_ready(1'b1), .s(w32_s), .cout(w32_cout), .ovf(w32_ovf), .zero(w32_zero)
    );

    cla_pipe_addsub #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(w4_in_valid), .in_ready(w4_in_ready),
        .a(w4_a), .b(w4_b), .op(OP_ADD), .cin(1'b0), .out_valid(w4_out_valid),
        .out_ready(1'b1), .s(w4_s), .cout(w4_cout), .ovf(w4_ovf), .zero(w4_zero)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Entered just after a rising edge; leaves just after the edge that consumes the result.
    task automatic run_op(input string tag, input op_t o, input logic [15:0] va, input logic [15:0] vb,
                          input logic vc, input logic [15:0] es, input logic ec, input logic eo,
                          input logic ez);
        op = o; a = va; b = vb; cin = vc; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        check({tag, "/in_ready"}, 64'(in_ready), 64'h1);
        @(posedge clk); #1;
        in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
        @(negedge clk);
        check({tag, "/early_valid"}, 64'(out_valid), 64'h0);
        @(negedge clk);
        check({tag, "/out_valid"}, 64'(out_valid), 64'h1);
        check({tag, "/s"}, 64'(s), 64'(es));
        check({tag, "/cout"}, 64'(cout), 64'(ec));
        check({tag, "/ovf"}, 64'(ovf), 64'(eo));
        check({tag, "/zero"}, 64'(zero), 64'(ez));
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned bidx;
        logic        acc;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0; op = OP_ADD;
        w32_in_valid = 1'b0; w32_a = '0; w32_b = '0;
        w4_in_valid  = 1'b0; w4_a  = '0; w4_b  = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst/out_valid", 64'(out_valid), 64'h0);
        check("rst/s", 64'(s), 64'h0);
        check("rst/flags", 64'({cout, ovf, zero}), 64'h0);
        check("rst/in_ready", 64'(in_ready), 64'h1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_op("add",       OP_ADD,  16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
        run_op("add_chain", OP_ADD,  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        run_op("addc_ovf",  OP_ADDC, 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0);
        run_op("addc_c0",   OP_ADDC, 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
        run_op("sub_ovf",   OP_SUB,  16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        run_op("sub_neg",   OP_SUB,  16'h0001, 16'h0002, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        run_op("sub_zero",  OP_SUB,  16'h0005, 16'h0005, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        run_op("subb_b1",   OP_SUBB, 16'h0005, 16'h0003, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0);
        run_op("subb_b0",   OP_SUBB, 16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b1, 1'b0, 1'b0);

        // Backpressure: four beats k+k offered while the consumer stalls for five cycles.
        bidx = 0;
        for (int unsigned cyc = 0; cyc < 10; cyc++) begin
            out_ready = (cyc >= 5);
            in_valid  = (bidx < 4);
            op = OP_ADD; cin = 1'b0;
            a = 16'(bidx + 1); b = 16'(bidx + 1);
            @(negedge clk);
            check($sformatf("bp/in_ready@%0d", cyc), 64'(in_ready), 64'(cyc < 2 || cyc >= 5));
            acc = in_valid && in_ready;
            if (cyc >= 1) begin
                check($sformatf("bp/out_valid@%0d", cyc), 64'(out_valid), 64'(cyc >= 2 && cyc <= 8));
                if (cyc >= 2 && cyc <= 8)
                    check($sformatf("bp/s@%0d", cyc), 64'(s), (cyc <= 5) ? 64'd2 : 64'(2 * (cyc - 4)));
            end
            @(posedge clk); #1;
            if (acc) bidx++;
        end
        check("bp/accepted", 64'(bidx), 64'd4);
        in_valid = 1'b0;

        // Wide and narrow instances, single beat each.
        w32_a = 32'h0000_FFFF; w32_b = 32'h0000_0001; w32_in_valid = 1'b1;
        w4_a  = 4'hF;          w4_b  = 4'h1;          w4_in_valid  = 1'b1;
        @(posedge clk); #1;
        w32_in_valid = 1'b0; w4_in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("w32/out_valid", 64'(w32_out_valid), 64'h1);
        check("w32/s", 64'(w32_s), 64'h0001_0000);
        check("w32/cout", 64'(w32_cout), 64'h0);
        check("w4/out_valid", 64'(w4_out_valid), 64'h1);
        check("w4/s", 64'(w4_s), 64'h0);
        check("w4/cout_zero", 64'({w4_cout, w4_zero, w4_ovf}), 64'b110);
        @(posedge clk); #1;

        // Reset with two beats in flight.
        out_ready = 1'b0; op = OP_ADD; cin = 1'b0;
        a = 16'h0011; b = 16'h0022; in_valid = 1'b1;
        @(posedge clk); #1;
        a = 16'h0100; b = 16'h0200;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("mid/full_valid", 64'(out_valid), 64'h1);
        check("mid/full_ready", 64'(in_ready), 64'h0);
        check("mid/full_s", 64'(s), 64'h0033);
        #2 rst_n = 1'b0;
        #1;
        check("mid/rst_valid", 64'(out_valid), 64'h0);
        check("mid/rst_s", 64'(s), 64'h0);
        check("mid/rst_flags", 64'({cout, ovf, zero}), 64'h0);
        check("mid/rst_ready", 64'(in_ready), 64'h1);
        @(posedge clk); #1;
        rst_n = 1'b1; out_ready = 1'b1;
        for (int unsigned i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("mid/stale@%0d", i), 64'(out_valid), 64'h0);
        end
        @(posedge clk); #1;
        run_op("post_rst", OP_ADD, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cla_pipe_addsub.md
# cla_pipe_addsub

Parametrised, two-stage pipelined carry-lookahead adder/subtractor with valid/ready handshakes on both sides. It is built from 4-bit lookahead groups and a second-level group-carry lookahead, and generalises the fixed 16-bit combinational adder to any multiple-of-4 width. It adds subtract, carry/borrow-in modes and status flags. It sits between register-file operand fetch and writeback in the datapath.

## Interface
- `WIDTH`, default 16: operand/result width in bits; must be a multiple of 4 and ≥ 4. Illegal values fail at elaboration.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  operand beat valid
- `in_ready`  out  1  block can accept a beat this cycle
- `a`  in  WIDTH  operand A
- `b`  in  WIDTH  operand B
- `op`  in  2  operation, `op_t` from `cla_pkg`
- `cin`  in  1  carry/borrow-in, used only by ADDC/SUBB
- `out_valid`  out  1  result beat valid
- `out_ready`  in  1  consumer accepts result
- `s`  out  WIDTH  result
- `cout`  out  1  carry-out of the internal addition
- `ovf`  out  1  signed two's-complement overflow
- `zero`  out  1  `s == 0`

## Operation
- Internal form: `s = a + b' + c0`.
  - ADD (00): `b' = b`, `c0 = 0`.
  - SUB (01): `b' = ~b`, `c0 = 1`.
  - ADDC (10): `b' = b`, `c0 = cin`.
  - SUBB (11): `b' = ~b`, `c0 = ~cin`, where `cin = 1` means borrow.
- Bit level: `g = a & b'`, `p = a | b'`, sum bit = `a ^ b' ^ carry`.
- Group level: 4-bit group `G/P` as standard lookahead, with `P = p0&p1&p2&p3`.
- Stage 1, on an accepted input beat: compute per-bit `g/p` and per-group `G/P`. Register `a`, `b'`, `c0`, the group `G/P` vectors and the bit `g/p` vectors.
- Stage 2: compute group carries from the registered `G/P` and `c0` by a second-level lookahead, one expression per group, with no ripple between groups. Then compute in-group carries and sums. Register `s` and the flags.
- `cout` is the carry out of the MSB group. For SUB/SUBB, `cout = 1` means no borrow.
- `ovf = (a[MSB] == b'[MSB]) && (s[MSB] != a[MSB])`.
- `zero` is computed from the final sum before registering.
- Handshake:
  - A beat transfers when valid && ready on the same edge.
  - Each stage holds a valid bit: `ready_k = !valid_k || ready_{k+1}`, with `ready_3 = out_ready`.
  - `in_ready` is `ready_1`, combinational from the stage valids and `out_ready` only; it never depends on `in_valid`.
  - A stalled stage holds its data and valid unchanged.
  - Results leave in acceptance order; none is dropped or duplicated.
- `out_valid`, once high, stays high with `s/cout/ovf/zero` stable until accepted.
- Simultaneous accept-out and accept-in on a full pipeline advances both stages in the same cycle, so full throughput is kept.
- Reset, asynchronous, any time: all valid bits clear, in-flight beats are discarded, all outputs go to 0. `in_ready = 1` once the valids are clear.

## Timing
- Latency: a beat accepted at edge N has `out_valid` high after edge N+2, when not stalled.
- Throughput: one beat per cycle while `out_ready` stays high.
- Capacity: 2 beats in flight. `in_ready` goes low only when both stages are valid and `out_ready = 0`.
- Reset values: `out_valid = 0`, `s = 0`, `cout = 0`, `ovf = 0`, `zero = 0`, all internal valids 0.
- Deassertion of `rst_n` is expected synchronised externally. The first beat may be accepted on the first edge after release.
- Critical path per stage is one lookahead level. Stage 2 holds the group-carry lookahead plus the in-group lookahead and XOR.

## Structure
- `cla_pkg` contents:
  - `typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_ADDC, OP_SUBB} op_t`.
  - `localparam GROUP_W = 4`.
  - Function `group_carries(G, P, c0)` returning the NGROUP carry vector.
- Sub-module `cla_group4`: combinational 4-bit group. Inputs are bit `g/p` and the group carry-in. Outputs are `G`, `P`, the 4 sum bits and internal carries. It is instantiated `WIDTH/4` times by a generate loop in each stage as needed.
- Top level `cla_pipe_addsub`: operand conditioning, two pipeline registers, handshake valids, flag logic.

## Test plan
- ADD, WIDTH=16: 0x1234 + 0x4321, `out_ready = 1` → `s = 0x5555`, `cout = 0`, `ovf = 0`, `zero = 0`, `out_valid` exactly 2 cycles after accept.
- Full carry chain, WIDTH=16: ADD 0xFFFF + 0x0001 → `s = 0x0000`, `cout = 1`, `zero = 1`, `ovf = 0`. ADDC 0x7FFF + 0x0000 with `cin = 1` → `s = 0x8000`, `ovf = 1`.
- SUB/SUBB, WIDTH=16:
  - SUB 0x8000 − 0x0001 → `s = 0x7FFF`, `ovf = 1`, `cout = 1`.
  - SUB 0x0001 − 0x0002 → `s = 0xFFFF`, `cout = 0`.
  - SUBB 0x0005 − 0x0003 with `cin = 1` → `s = 0x0001`.
- Backpressure: offer 4 back-to-back ADDs (k + k for k = 1..4) while `out_ready = 0` for 5 cycles → only 2 accepted, `in_ready = 0` from cycle 2. After release, results 2, 4, 6, 8 appear in order with no gaps or repeats.
- Parametrisation: WIDTH=32, ADD 0x0000FFFF + 1 → 0x00010000 with carry across groups. WIDTH=4, ADD 0xF + 0x1 → `s = 0`, `cout = 1`. WIDTH=6 fails elaboration.
- Reset mid-operation: assert `rst_n = 0` with 2 beats in flight → all outputs 0 and `out_valid = 0` asynchronously. After release, no stale result appears and the next beat has 2-cycle latency.
